// File: rtl/ksa_if.sv
// ksa_if: en/rdy start handshake plus the single-port S memory bus used by
// the ARC4 key-scheduling stage.
//
// Handshake: a start is accepted on a posedge where rdy=1 and en=1, and key
// is captured on that same edge. en while rdy=0 is ignored. rdy stays low
// from the accepting edge until the stage has finished and is idle again.
//
// Memory bus: one access per cycle. s_wren=1 writes s_wrdata to s_addr on the
// posedge. A read presents s_addr and s_rddata is valid one cycle later.
interface ksa_if #(
  parameter int KEY_BYTES = 3
);
  logic                   en;
  logic                   rdy;
  logic [8*KEY_BYTES-1:0] key;
  logic [7:0]             s_addr;
  logic [7:0]             s_rddata;
  logic [7:0]             s_wrdata;
  logic                   s_wren;

  // The key-scheduling stage: drives the memory bus and rdy
  modport master (
    input  en, key, s_rddata,
    output rdy, s_addr, s_wrdata, s_wren
  );

  // The environment: requests a run and owns the S memory
  modport slave (
    output en, key, s_rddata,
    input  rdy, s_addr, s_wrdata, s_wren
  );
endinterface

// File: rtl/ksa.sv
// ksa: ARC4 key-scheduling stage. Permutes the shared 256x8 S memory with the
// captured key: for i=0..255 { j += S[i] + key[i mod KEY_BYTES]; swap S[i],S[j] }.
// Each iteration takes 8 cycles: RD_I, LT_I, CALC, RD_J, LT_J, WR_I, WR_J, NEXT.
// Key byte 0 is the most significant byte of key.
//
// Optional feature macro INIT_FILL_EN: when defined, S[a]=a is written for
// a=0..255 (FILL state) before the schedule starts. When undefined, S must
// already hold the identity permutation when en is accepted.
//
// o_dbg_state exposes the current state encoding for observation.
module ksa #(
  parameter int KEY_BYTES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  ksa_if.master      bus,
  output logic [3:0] o_dbg_state
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_FILL = 4'd1,
    S_RD_I = 4'd2,
    S_LT_I = 4'd3,
    S_CALC = 4'd4,
    S_RD_J = 4'd5,
    S_LT_J = 4'd6,
    S_WR_I = 4'd7,
    S_WR_J = 4'd8,
    S_NEXT = 4'd9,
    S_DONE = 4'd10
  } state_t;

  state_t                 r_state;
  logic                   r_rdy;
  logic [7:0]             r_i;
  logic [7:0]             r_j;
  logic [7:0]             r_si;
  logic [7:0]             r_sj;
  logic [8*KEY_BYTES-1:0] r_key;
  logic [KW-1:0]          r_kidx;
  logic [7:0]             w_key_byte;

  // Select key byte (i mod KEY_BYTES); byte 0 sits in the top bits of the key
  always_comb begin
    w_key_byte = 8'd0;
    for (int k = 0; k < KEY_BYTES; k++) begin
      if (r_kidx == KW'(k)) w_key_byte = r_key[8*(KEY_BYTES-1-k) +: 8];
    end
  end

  // Memory bus is decoded from the state; idle states leave the bus at zero
  always_comb begin
    bus.s_addr   = 8'd0;
    bus.s_wrdata = 8'd0;
    bus.s_wren   = 1'b0;
    case (r_state)
      S_FILL: begin
        bus.s_addr   = r_i;
        bus.s_wrdata = r_i;
        bus.s_wren   = 1'b1;
      end
      S_RD_I: bus.s_addr = r_i;
      S_RD_J: bus.s_addr = r_j;
      S_WR_I: begin
        bus.s_addr   = r_i;
        bus.s_wrdata = r_sj;
        bus.s_wren   = 1'b1;
      end
      S_WR_J: begin
        bus.s_addr   = r_j;
        bus.s_wrdata = r_si;
        bus.s_wren   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.rdy     = r_rdy;
  assign o_dbg_state = r_state;

  // Control FSM with the i/j indices, latched S values and captured key
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rdy   <= 1'b1;
      r_i     <= 8'd0;
      r_j     <= 8'd0;
      r_si    <= 8'd0;
      r_sj    <= 8'd0;
      r_key   <= '0;
      r_kidx  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_rdy && bus.en) begin
            r_key  <= bus.key;
            r_i    <= 8'd0;
            r_j    <= 8'd0;
            r_kidx <= '0;
            r_rdy  <= 1'b0;
`ifdef INIT_FILL_EN
            r_state <= S_FILL;
`else
            r_state <= S_RD_I;
`endif
          end
        end
`ifdef INIT_FILL_EN
        S_FILL: begin
          // i doubles as the fill address and wraps back to 0 for the schedule
          r_i <= r_i + 8'd1;
          if (r_i == 8'hFF) r_state <= S_RD_I;
        end
`endif
        S_RD_I: r_state <= S_LT_I;
        S_LT_I: begin
          r_si    <= bus.s_rddata;
          r_state <= S_CALC;
        end
        S_CALC: begin
          r_j     <= r_j + r_si + w_key_byte;
          r_state <= S_RD_J;
        end
        S_RD_J: r_state <= S_LT_J;
        S_LT_J: begin
          r_sj    <= bus.s_rddata;
          r_state <= S_WR_I;
        end
        S_WR_I: r_state <= S_WR_J;
        S_WR_J: r_state <= S_NEXT;
        S_NEXT: begin
          r_i    <= r_i + 8'd1;
          r_kidx <= (r_kidx == KW'(KEY_BYTES-1)) ? '0 : r_kidx + KW'(1);
          r_state <= (r_i == 8'hFF) ? S_DONE : S_RD_I;
        end
        S_DONE: begin
          r_rdy   <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_rdy   <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ksa.sv
// tb_ksa: directed bench for the ARC4 key-scheduling stage. Owns a 256x8
// synchronous-read S memory, checks every write against a reference write
// sequence, checks hand-computed writes of the first iterations, the final S
// contents, latency, busy rejection, mid-run reset and back-to-back starts.
// Build with +define+INIT_FILL_EN to exercise the fill variant.
module tb_ksa;

`ifdef INIT_FILL_EN
  localparam int EXP_LAT = 2306;
  localparam int FO      = 256;
`else
  localparam int EXP_LAT = 2050;
  localparam int FO      = 0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_id;
  logic [3:0] dbg_state;

  always #5 clk = ~clk;

  ksa_if #(.KEY_BYTES(3)) bus ();

  ksa #(.KEY_BYTES(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- S memory ----------------
  logic [7:0] mem [256];

  always @(posedge clk) begin
    if (load_id) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (bus.s_wren) begin
      mem[bus.s_addr] <= bus.s_wrdata;
    end
    bus.s_rddata <= mem[bus.s_addr];
  end

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] wr_log[$];
  logic [7:0]  ms [256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference KSA on the model array; queues the expected {addr,data} writes
  task automatic build_exp(input logic [23:0] k);
    logic [7:0] j;
    logic [7:0] si;
    logic [7:0] sj;
    logic [7:0] kb;
    exp_q.delete();
`ifdef INIT_FILL_EN
    for (int a = 0; a < 256; a++) begin
      ms[a] = 8'(a);
      exp_q.push_back({8'(a), 8'(a)});
    end
`endif
    j = 8'd0;
    for (int i = 0; i < 256; i++) begin
      case (i % 3)
        0: kb = k[23:16];
        1: kb = k[15:8];
        default: kb = k[7:0];
      endcase
      j  = j + ms[i] + kb;
      si = ms[i];
      sj = ms[j];
      exp_q.push_back({8'(i), sj});
      exp_q.push_back({j, si});
      ms[i] = sj;
      ms[j] = si;
    end
  endtask

  // Write monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.s_wren === 1'b1) begin
      wr_log.push_back({bus.s_addr, bus.s_wrdata});
      if (exp_q.size() == 0) check("wr_extra", {bus.s_addr, bus.s_wrdata}, 32'hFFFF_FFFF);
      else                   check("wr_seq", {bus.s_addr, bus.s_wrdata}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_identity();
    @(negedge clk);
    load_id = 1'b1;
    @(negedge clk);
    load_id = 1'b0;
    for (int k = 0; k < 256; k++) ms[k] = 8'(k);
  endtask

  // Present en/key at a negedge where rdy is high; returns after the accepting edge
  task automatic start(input logic [23:0] k);
    @(negedge clk);
    check("start_rdy", bus.rdy, 1'b1);
    wr_log.delete();
    build_exp(k);
    bus.key = k;
    bus.en  = 1'b1;
    @(posedge clk);
  endtask

  // Latency counts the accepting cycle as 1; returns at the negedge where rdy is seen high
  task automatic wait_done(input int chg_at, input logic [23:0] chg_key, input bit keep_en,
                           output int lat);
    lat = 1;
    forever begin
      @(negedge clk);
      if (!keep_en) bus.en = 1'b0;
      if (lat == chg_at) bus.key = chg_key;
      if (bus.rdy === 1'b1) break;
      if (lat >= 6000) begin
        check("timeout", lat, EXP_LAT);
        break;
      end
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic end_checks(input int lat);
    int nbad;
    check("latency", lat, EXP_LAT);
    check("exp_q_left", exp_q.size(), 0);
    check("wr_count", wr_log.size(), FO + 512);
    nbad = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== ms[k]) nbad++;
    check("final_s_bad_entries", nbad, 0);
  endtask

  function automatic logic [15:0] log_at(input int idx);
    return (idx < wr_log.size()) ? wr_log[idx] : 16'hDEAD;
  endfunction

  // ---------------- main sequence ----------------
  initial begin : main
    int lat;
    int lat_a;
    int nwr;
    rst_n       = 1'b0;
    load_id     = 1'b0;
    bus.en      = 1'b0;
    bus.key     = 24'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdy", bus.rdy, 1'b1);
    check("rst_wren", bus.s_wren, 1'b0);
    check("rst_addr", bus.s_addr, 8'h00);
    check("rst_state", dbg_state, 4'd0);
    rst_n = 1'b1;

    // Idle with en low: no memory access
    nwr = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.s_wren !== 1'b0) nwr++;
    end
    check("idle_no_wr", nwr, 0);
    check("idle_state", dbg_state, 4'd0);

    // key 0: i=0,1 are same-address writes, i=2 swaps S[2]/S[3]
    load_identity();
    start(24'h000000);
    wait_done(0, 24'h0, 1'b0, lat);
    end_checks(lat);
`ifdef INIT_FILL_EN
    check("fill_first", log_at(0), 16'h0000);
    check("fill_mid", log_at(128), 16'h8080);
    check("fill_last", log_at(255), 16'hFFFF);
`endif
    check("k0_i0_wri", log_at(FO + 0), 16'h0000);
    check("k0_i0_wrj", log_at(FO + 1), 16'h0000);
    check("k0_i1_wri", log_at(FO + 2), 16'h0101);
    check("k0_i1_wrj", log_at(FO + 3), 16'h0101);
    check("k0_i2_wri", log_at(FO + 4), 16'h0203);
    check("k0_i2_wrj", log_at(FO + 5), 16'h0302);

    // key 000102
    load_identity();
    start(24'h000102);
    wait_done(0, 24'h0, 1'b0, lat);
    end_checks(lat);
    check("k012_i1_wri", log_at(FO + 2), 16'h0102);
    check("k012_i1_wrj", log_at(FO + 3), 16'h0201);
    check("k012_i2_wri", log_at(FO + 4), 16'h0205);
    check("k012_i2_wrj", log_at(FO + 5), 16'h0501);

    // key FFFFFF: j wraps modulo 256
    load_identity();
    start(24'hFFFFFF);
    wait_done(0, 24'h0, 1'b0, lat);
    end_checks(lat);
    check("kff_i0_wri", log_at(FO + 0), 16'h00FF);
    check("kff_i0_wrj", log_at(FO + 1), 16'hFF00);
    check("kff_i1_wri", log_at(FO + 2), 16'h0100);
    check("kff_i1_wrj", log_at(FO + 3), 16'hFF01);

    // Busy rejection: en held high, key changed mid-run
    load_identity();
    start(24'h000102);
    wait_done(100, 24'h123456, 1'b1, lat);
    bus.en = 1'b0;
    end_checks(lat);
    repeat (5) @(negedge clk);
    check("busy_no_restart_state", dbg_state, 4'd0);
    check("busy_no_restart_rdy", bus.rdy, 1'b1);

    // Reset 100 cycles after accept
    load_identity();
    start(24'h0A0B0C);
    bus.en = 1'b0;
    repeat (99) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    exp_q.delete();
    @(negedge clk);
    check("midrst_state", dbg_state, 4'd0);
    check("midrst_rdy", bus.rdy, 1'b1);
    check("midrst_wren", bus.s_wren, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    load_identity();
    start(24'h0A0B0C);
    wait_done(0, 24'h0, 1'b0, lat);
    end_checks(lat);

    // Back-to-back: second en presented on the first cycle rdy is high
    load_identity();
    start(24'h000102);
    wait_done(0, 24'h0, 1'b1, lat_a);
    end_checks(lat_a);
    wr_log.delete();
    build_exp(24'hC0FFEE);
    bus.key = 24'hC0FFEE;
    @(posedge clk);
    wait_done(0, 24'h0, 1'b0, lat);
    end_checks(lat);
    check("b2b_same_latency", lat, lat_a);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
